// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared calculator definitions. Holds the keypad codes, the
//                operator ASCII codes, the tokenizer state type and small
//                key-decoding helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

    // Keypad codes; 0-9 are digits.
    localparam logic [3:0] c_KEY_PLUS  = 4'd10;
    localparam logic [3:0] c_KEY_MINUS = 4'd11;
    localparam logic [3:0] c_KEY_MUL   = 4'd12;
    localparam logic [3:0] c_KEY_DIV   = 4'd13;
    localparam logic [3:0] c_KEY_EQ    = 4'd14;
    localparam logic [3:0] c_KEY_CLR   = 4'd15;

    // Operator tokens travel downstream as ASCII.
    localparam logic [7:0] c_ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] c_ASCII_MINUS = 8'h2D;
    localparam logic [7:0] c_ASCII_MUL   = 8'h2A;
    localparam logic [7:0] c_ASCII_DIV   = 8'h2F;

    // Largest operand the downstream signed arithmetic can hold.
    localparam logic [63:0] c_ACC_LIMIT = 64'h0000_0000_7FFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_NUM      = 3'd1,
        ST_EMIT_NUM = 3'd2,
        ST_EMIT_OP  = 3'd3,
        ST_ERR      = 3'd4
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    function automatic logic is_op(input logic [3:0] code);
        return (code >= c_KEY_PLUS) && (code <= c_KEY_DIV);
    endfunction

    function automatic logic [7:0] op_ascii(input logic [3:0] code);
        logic [7:0] v;
        case (code)
            c_KEY_MINUS: v = c_ASCII_MINUS;
            c_KEY_MUL:   v = c_ASCII_MUL;
            c_KEY_DIV:   v = c_ASCII_DIV;
            default:     v = c_ASCII_PLUS;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/expr_tokenizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : expr_tokenizer_if
//  Description : Keypad input channel and token output channel of the
//                expression tokenizer, plus its error flag.
//                master = keypad/token consumer side, slave = tokenizer.
//  Revision    : 1.0  initial release
// ============================================================================
interface expr_tokenizer_if #(
    parameter int W = 32
);
    logic         key_valid;
    logic [3:0]   key_code;
    logic         key_ready;
    logic         tok_valid;
    logic         tok_ready;
    logic         tok_is_op;
    logic [W-1:0] tok_data;
    logic         tok_last;
    logic         err;

    modport master (
        output key_valid, key_code, tok_ready,
        input  key_ready, tok_valid, tok_is_op, tok_data, tok_last, err
    );

    modport slave (
        input  key_valid, key_code, tok_ready,
        output key_ready, tok_valid, tok_is_op, tok_data, tok_last, err
    );
endinterface
`default_nettype wire

// File: rtl/expr_tokenizer_dec_accum.sv
`default_nettype none
// ============================================================================
//  Module      : dec_accum
//  Description : Decimal accumulator step: acc*10 + digit, with a flag when
//                the result no longer fits a positive 31-bit operand.
//  Revision    : 1.0  initial release
// ============================================================================
module dec_accum
    import calc_pkg::*;
#(
    parameter int W = 32
) (
    input  wire logic [W-1:0] i_acc,
    input  wire logic [3:0]   i_digit,
    output logic      [W-1:0] o_acc,
    output logic              o_ovf
);

    // Wide intermediate so the overflow compare sees the true product.
    logic [63:0] w_wide;

    // Multiply-by-ten-plus-digit in full precision.
    always_comb begin
        w_wide = 64'(i_acc) * 64'd10 + 64'(i_digit);
    end

    assign o_acc = w_wide[W-1:0];
    assign o_ovf = (w_wide > c_ACC_LIMIT);

endmodule
`default_nettype wire

// File: rtl/expr_tokenizer.sv
`default_nettype none
// ============================================================================
//  Module      : expr_tokenizer
//  Description : Turns keypad codes into operand/operator tokens for the
//                infix-to-postfix stage. Detects leading/double operators,
//                operand overflow and over-long expressions; any error is
//                held until 'C' is pressed.
//  Revision    : 1.0  initial release
// ============================================================================
module expr_tokenizer
    import calc_pkg::*;
#(
    parameter int MAX_TOKENS = 99,
    parameter int W          = 32
) (
    input wire logic         clk,
    input wire logic         rst,
    expr_tokenizer_if.slave  bus
);

    localparam int c_CNT_W = $clog2(MAX_TOKENS + 1) + 1;

    state_t             r_state;
    logic [W-1:0]       r_acc;
    logic [7:0]         r_op;
    logic               r_op_pend;
    logic               r_last;
    logic [c_CNT_W-1:0] r_tok_cnt;

    state_t             w_state_nxt;
    logic [W-1:0]       w_acc_nxt;
    logic [7:0]         w_op_nxt;
    logic               w_op_pend_nxt;
    logic               w_last_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic               w_key_ready;
    logic               w_key_acc;
    logic               w_tok_valid;
    logic               w_tok_is_op;
    logic [W-1:0]       w_tok_data;
    logic               w_tok_last;
    logic               w_err;
    logic               w_cnt_full;

    logic [W-1:0]       w_accum_val;
    logic               w_accum_ovf;

    dec_accum #(.W(W)) u_dec_accum (
        .i_acc   (r_acc),
        .i_digit (bus.key_code),
        .o_acc   (w_accum_val),
        .o_ovf   (w_accum_ovf)
    );

    assign w_key_acc  = bus.key_valid && w_key_ready;
    // An operator commits the current operand, the operator and at least one
    // more operand, so three more tokens must still fit.
    assign w_cnt_full = (int'(r_tok_cnt) + 3) > MAX_TOKENS;

    // Next-state, datapath updates and token/handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_op_nxt      = r_op;
        w_op_pend_nxt = r_op_pend;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_tok_cnt;
        w_key_ready   = 1'b0;
        w_tok_valid   = 1'b0;
        w_tok_is_op   = 1'b0;
        w_tok_data    = '0;
        w_tok_last    = 1'b0;
        w_err         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_key_ready = 1'b1;
                if (w_key_acc) begin
                    if (is_digit(bus.key_code)) begin
                        w_acc_nxt   = W'(bus.key_code);
                        w_state_nxt = ST_NUM;
                    end else if (bus.key_code != c_KEY_CLR) begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_NUM: begin
                w_key_ready = 1'b1;
                if (w_key_acc) begin
                    if (is_digit(bus.key_code)) begin
                        if (w_accum_ovf) begin
                            w_state_nxt = ST_ERR;
                        end else begin
                            w_acc_nxt = w_accum_val;
                        end
                    end else if (is_op(bus.key_code)) begin
                        if (w_cnt_full) begin
                            w_state_nxt = ST_ERR;
                        end else begin
                            w_op_nxt      = op_ascii(bus.key_code);
                            w_op_pend_nxt = 1'b1;
                            w_last_nxt    = 1'b0;
                            w_state_nxt   = ST_EMIT_NUM;
                        end
                    end else if (bus.key_code == c_KEY_EQ) begin
                        w_op_pend_nxt = 1'b0;
                        w_last_nxt    = 1'b1;
                        w_state_nxt   = ST_EMIT_NUM;
                    end
                end
            end
            ST_EMIT_NUM: begin
                w_tok_valid = 1'b1;
                w_tok_data  = r_acc;
                w_tok_last  = r_last;
                if (bus.tok_ready) begin
                    w_cnt_nxt = r_last ? '0 : r_tok_cnt + c_CNT_W'(1);
                    if (r_op_pend) begin
                        w_state_nxt = ST_EMIT_OP;
                    end else begin
                        w_acc_nxt   = '0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_EMIT_OP: begin
                w_tok_valid = 1'b1;
                w_tok_is_op = 1'b1;
                w_tok_data  = W'(r_op);
                if (bus.tok_ready) begin
                    w_cnt_nxt     = r_tok_cnt + c_CNT_W'(1);
                    w_acc_nxt     = '0;
                    w_op_pend_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_ERR: begin
                w_key_ready = 1'b1;
                w_err       = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // 'C' wins in every state that can accept a key.
        if (w_key_acc && (bus.key_code == c_KEY_CLR)) begin
            w_acc_nxt     = '0;
            w_cnt_nxt     = '0;
            w_op_pend_nxt = 1'b0;
            w_last_nxt    = 1'b0;
            w_state_nxt   = ST_IDLE;
        end
    end

    // State and datapath registers; reset drops any token in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_op      <= '0;
            r_op_pend <= 1'b0;
            r_last    <= 1'b0;
            r_tok_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_op      <= w_op_nxt;
            r_op_pend <= w_op_pend_nxt;
            r_last    <= w_last_nxt;
            r_tok_cnt <= w_cnt_nxt;
        end
    end

    assign bus.key_ready = w_key_ready;
    assign bus.tok_valid = w_tok_valid;
    assign bus.tok_is_op = w_tok_is_op;
    assign bus.tok_data  = w_tok_data;
    assign bus.tok_last  = w_tok_last;
    assign bus.err       = w_err;

endmodule
`default_nettype wire

// File: doc/expr_tokenizer.md
EXPR_TOKENIZER -- requirements
Module: expr_tokenizer

Interface
REQ-001 SHALL have parameter MAX_TOKENS, default 99, meaning the maximum number of tokens in one expression.
REQ-002 SHALL have parameter W, default 32, meaning the operand and token data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port key_valid, input, 1, meaning a keypad code is offered.
REQ-006 SHALL have port key_code, input, 4, with codes 0-9 = digit, 10 = '+', 11 = '-', 12 = '*', 13 = '/', 14 = '=', 15 = 'C' (clear).
REQ-007 SHALL have port key_ready, output, 1, meaning a key is accepted when key_valid && key_ready.
REQ-008 SHALL have port tok_valid, output, 1, meaning a token is offered downstream to the infix-to-postfix stage.
REQ-009 SHALL have port tok_ready, input, 1, meaning the token is transferred when tok_valid && tok_ready.
REQ-010 SHALL have port tok_is_op, output, 1, where 1 = operator token and 0 = operand token.
REQ-011 SHALL have port tok_data, output, W, carrying the unsigned operand value, or the operator as ASCII ('+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F).
REQ-012 SHALL have port tok_last, output, 1, marking the final token of an expression.
REQ-013 SHALL have port err, output, 1, a sticky syntax or overflow error flag.

Function
REQ-014 SHALL implement states IDLE (expect operand), NUM (accumulating), EMIT_NUM, EMIT_OP and ERR.
REQ-015 SHALL drive key_ready=1 in IDLE, NUM and ERR, and key_ready=0 in EMIT_NUM and EMIT_OP.
REQ-016 SHALL, on a digit accepted in IDLE, load acc=d and enter NUM; on a digit in NUM, set acc=acc*10+d.
REQ-017 SHALL enter ERR if acc*10+d exceeds 2^31-1; leading zeros are legal.
REQ-018 SHALL, on an operator accepted in NUM, latch the operator and enter EMIT_NUM with tok_last=0.
REQ-019 SHALL, on '=' accepted in NUM, enter EMIT_NUM with tok_last=1 and no pending operator.
REQ-020 SHALL, in EMIT_NUM, assert tok_valid=1, tok_is_op=0, tok_data=acc one cycle after key acceptance.
REQ-021 SHALL, on handshake in EMIT_NUM, go to EMIT_OP if an operator is pending, otherwise to IDLE.
REQ-022 SHALL, in EMIT_OP, assert tok_valid=1, tok_is_op=1, tok_data=ASCII op, tok_last=0; handshake clears acc and enters IDLE.
REQ-023 SHALL hold tok_valid, tok_data, tok_is_op and tok_last stable while tok_valid && !tok_ready.
REQ-024 SHALL enter ERR on an operator or '=' accepted in IDLE (leading operator, two operators in a row, or '=' after an operator).
REQ-025 SHALL keep tok_cnt, the tokens emitted in the current expression, increment it per handshake, and reset it to 0 after the tok_last handshake.
REQ-026 SHALL enter ERR, instead of EMIT_NUM, on an operator accepted in NUM when tok_cnt+3 > MAX_TOKENS.
REQ-027 SHALL, in ERR, assert err=1 and accept and discard every key except 'C'.
REQ-028 SHALL, on 'C' accepted in any key_ready state, clear acc, tok_cnt, the pending op and err, and enter IDLE next cycle.
REQ-029 SHALL never drive tok_valid while in ERR; a partially sent expression is abandoned.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, enter IDLE with acc=0, tok_cnt=0, tok_valid=0, tok_is_op=0, tok_data=0, tok_last=0, err=0 and key_ready=1.
REQ-031 SHALL give rst priority over all handshakes; a token offered when rst asserts is dropped.

Structure
REQ-032 SHALL take from the shared package calc_pkg: the key code constants, the operator ASCII constants, and the state enum type.
REQ-033 SHALL place the multiply-by-10-plus-digit logic with overflow detect in one sub-module, dec_accum.

Verification
REQ-034 SHALL verify that keys 1,2,+,3,= with tok_ready=1 produce tokens (12,op0), (0x2B,op1), (3,op0,last).
REQ-035 SHALL verify that keys 5,* with tok_ready held 0 for 4 cycles keep tok_data=5 stable, key_ready=0, and emit 0x2A after release.
REQ-036 SHALL verify that '+' as the first key gives err=1 next cycle and no token; a subsequent 'C' gives err=0, IDLE.
REQ-037 SHALL verify that digits 2,1,4,7,4,8,3,6,4,8 (2147483648) give err=1 on the last digit, and that 2147483647 followed by '=' emits 0x7FFFFFFF.
REQ-038 SHALL verify that with MAX_TOKENS=5, the keys 1+2+3+ give err on the third '+' while 1+2+3= emits 5 tokens.
REQ-039 SHALL verify that rst asserted during EMIT_OP gives tok_valid=0 next cycle and a following expression tokenizes correctly.
